intr_prio_ctrl: RTL and testbench
=================================

Name: intr_prio_ctrl

Overview:
- Stage directly downstream of the interrupt status registers (ISRA/ISRB, 16 sources plus NMI).
- Takes the latched pending bits and selects the highest-priority eligible source.
- Raises a request to the CPU and completes an ack/vector handshake.
- On ack, pulses a clear back to the status stage and tracks in-service sources until end-of-interrupt (EOI).

Parameters:
- NUM_SRC, 16, number of maskable sources; index 0 = highest priority.
- ID_W, 5, vector width; must satisfy 2**ID_W > NUM_SRC. Vector value NUM_SRC denotes NMI.

Ports:
- pclk  in  1  clock
- preset_n  in  1  synchronous active-low reset
- pend_i  in  NUM_SRC  pending, enabled status bits from ISRA/ISRB
- nmi_i  in  1  NMI pending
- int_ack_i  in  1  CPU acknowledge, one-cycle pulse
- eoi_i  in  1  end-of-interrupt strobe
- eoi_id_i  in  ID_W  vector being retired
- irq_o  out  1  maskable interrupt request to CPU
- nmi_o  out  1  NMI request to CPU
- vec_o  out  ID_W  current candidate vector; valid while irq_o or nmi_o is high
- vec_valid_o  out  1  one-cycle pulse, cycle after ack; vec_o is the acknowledged vector
- clr_o  out  NUM_SRC  one-hot, one-cycle clear pulse to the status register
- nmi_clr_o  out  1  one-cycle NMI status clear
- isr_o  out  NUM_SRC+1  in-service bits; MSB = NMI

Behaviour:
- Reset: synchronous on pclk while preset_n=0. All outputs 0, isr cleared, FSM = IDLE. Reset asserted mid-handshake drops irq_o/nmi_o at that edge; a pending ack is discarded.
- Eligibility:
  - NMI is eligible when nmi_i=1 and isr[NUM_SRC]=0.
  - Source k is eligible when pend_i[k]=1, isr[k]=0, and k is numerically below the lowest in-service index (see nesting feature).
  - Winner: eligible NMI first, otherwise the lowest eligible k.
- FSM states: IDLE, REQ, ACK.
  - IDLE: if a winner exists, register cand <= winner and move to REQ. irq_o or nmi_o rises 1 cycle after pend_i/nmi_i is seen (latency 1).
  - REQ: irq_o=1 (or nmi_o=1 if cand = NMI); vec_o=cand.
    - Winner is re-evaluated every cycle; a higher-priority winner replaces cand (preemption before ack), including a maskable-to-NMI switch.
    - If no winner remains (pending withdrawn), return to IDLE and drop the request next cycle.
    - On int_ack_i: set isr[cand], move to ACK. The request deasserts on the ack edge.
  - ACK (one cycle):
    - vec_valid_o=1 with vec_o=cand.
    - clr_o[cand]=1, or nmi_clr_o=1 for NMI.
    - Next state IDLE; a new request may start the following cycle.
- int_ack_i in IDLE or ACK is ignored.
- EOI: eoi_i clears isr[eoi_id_i] in any state. An id with no in-service bit, or an id > NUM_SRC, is ignored.
- Same-cycle ack and EOI for the same id: the set dominates (bit remains 1).
- Clear latency: status clears one cycle after ACK. isr[cand] is already set, so the stale pend_i bit cannot re-request.

Optional Feature:
- INTR_NEST_EN defined: nested interrupts. A maskable source is eligible only if its index is below every in-service maskable index. NMI is always eligible unless NMI is itself in service.
- Not defined: a maskable source is eligible only when no maskable isr bit is set (single-level). NMI behaves the same in both modes.

Decomposition:
- Package intr_pkg:
  - state enum {IDLE, REQ, ACK};
  - localparam NUM_SRC_DEF=16;
  - function vec_nmi() returning NUM_SRC.
- Sub-module intr_prio_enc: combinational find-first-set over the eligible vector. Outputs index and found flag; parameterised by NUM_SRC.

Test Plan:
- pend_i=16'h0030 from reset → irq_o=1 after 1 cycle, vec_o=4; ack → vec_valid_o pulse with vec_o=4, clr_o=16'h0010, isr_o bit4=1.
- pend_i=16'h0100 in REQ, then pend_i=16'h0101 before ack → vec_o changes 8→0; ack yields vec 0, clr_o=16'h0001.
- With isr bit 4 set and INTR_NEST_EN defined: pend_i=16'h0004 → requests vec 2. Without the macro → no request until eoi_i with eoi_id_i=4.
- nmi_i=1 while REQ holds vec 3 → nmi_o=1, irq_o=0, vec_o=16; ack → nmi_clr_o pulse, isr_o[16]=1; second nmi_i ignored until EOI id 16.
- Withdraw: pend_i 16'h0080 for 1 cycle then 0 → irq_o pulses high then returns to 0, FSM back in IDLE, no clr_o.
- preset_n=0 during REQ with pend_i=16'hFFFF → irq_o=0 and isr_o=0 at that edge; after release, vec 0 is requested.

Source files
------------

// File: rtl/intr_prio_ctrl_pkg.sv
// Shared types and constants for the interrupt priority controller.
// Compile-time option: INTR_NEST_EN (nested maskable interrupts) is consumed
// by intr_prio_ctrl; nothing in this package depends on it.
package intr_pkg;

    localparam int NUM_SRC_DEF = 16;

    // Handshake FSM encoding; the top mirrors these as plain localparams.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } state_e;

    // The vector one past the last maskable source is reserved for NMI.
    function automatic int unsigned vec_nmi(input int unsigned num_src);
        return num_src;
    endfunction

endpackage

// File: rtl/intr_prio_ctrl_if.sv
// Status-stage / CPU facing signal bundle of the interrupt priority controller.
// slave  : the controller view.
// master : the environment view (status registers plus CPU).
interface intr_prio_ctrl_if #(
    parameter int NUM_SRC = 16,
    parameter int ID_W    = 5
) ();

    logic [NUM_SRC-1:0] pend_i;
    logic               nmi_i;
    logic               int_ack_i;
    logic               eoi_i;
    logic [ID_W-1:0]    eoi_id_i;
    logic               irq_o;
    logic               nmi_o;
    logic [ID_W-1:0]    vec_o;
    logic               vec_valid_o;
    logic [NUM_SRC-1:0] clr_o;
    logic               nmi_clr_o;
    logic [NUM_SRC:0]   isr_o;

    modport slave (
        input  pend_i, nmi_i, int_ack_i, eoi_i, eoi_id_i,
        output irq_o, nmi_o, vec_o, vec_valid_o, clr_o, nmi_clr_o, isr_o
    );

    modport master (
        output pend_i, nmi_i, int_ack_i, eoi_i, eoi_id_i,
        input  irq_o, nmi_o, vec_o, vec_valid_o, clr_o, nmi_clr_o, isr_o
    );

endinterface

// File: rtl/intr_prio_ctrl_enc.sv
// Find-first-set encoder: returns the lowest set index of vec (index 0 is the
// highest priority) and whether any bit is set at all.
module intr_prio_enc #(
    parameter int NUM_SRC = 16,
    parameter int ID_W    = 5
) (
    input  logic [NUM_SRC-1:0] vec,
    output logic [ID_W-1:0]    idx,
    output logic               found
);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = ID_W'(i);
                found = 1'b1;
            end else begin
                idx   = idx;
                found = found;
            end
        end
    end

endmodule

// File: rtl/intr_prio_ctrl.sv
// Interrupt priority controller: picks the highest-priority eligible source
// from the latched status bits, requests the CPU, completes the ack/vector
// handshake, pulses a status clear and tracks in-service sources until EOI.
// Compile-time option: define INTR_NEST_EN for nested maskable interrupts;
// otherwise any maskable in-service bit blocks all maskable requests.
module intr_prio_ctrl
    import intr_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int ID_W    = 5
) (
    input  logic                pclk,
    input  logic                preset_n,
    intr_prio_ctrl_if.slave     bus
);

    localparam int              ISR_W   = NUM_SRC + 1;
    localparam logic [ID_W-1:0] VEC_NMI = ID_W'(vec_nmi(NUM_SRC));

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_REQ  = 2'(REQ);
    localparam logic [1:0] ST_ACK  = 2'(ACK);

    logic [1:0]         state_r,     state_nxt_s;
    logic [ID_W-1:0]    cand_r,      cand_nxt_s;
    logic               irq_r,       irq_nxt_s;
    logic               nmi_r,       nmi_nxt_s;
    logic               vec_valid_r, vec_valid_nxt_s;
    logic [NUM_SRC-1:0] clr_r,       clr_nxt_s;
    logic               nmi_clr_r,   nmi_clr_nxt_s;
    logic [ISR_W-1:0]   isr_r,       isr_nxt_s;

    logic [NUM_SRC-1:0] allow_s;
    logic               blocked_s;
    logic [NUM_SRC-1:0] elig_s;
    logic               nmi_elig_s;
    logic [ID_W-1:0]    enc_idx_s;
    logic               enc_found_s;
    logic               win_valid_s;
    logic [ID_W-1:0]    win_vec_s;
    logic [ISR_W-1:0]   isr_set_s;
    logic [ISR_W-1:0]   eoi_clr_s;

`ifdef INTR_NEST_EN
    // Nesting: source k may interrupt only if no in-service bit sits at or below k.
    always_comb begin
        blocked_s = 1'b0;
        allow_s   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            blocked_s  = blocked_s | isr_r[k];
            allow_s[k] = ~blocked_s;
        end
    end
`else
    // Single level: any maskable in-service bit blocks every maskable source.
    always_comb begin
        blocked_s = |isr_r[NUM_SRC-1:0];
        allow_s   = {NUM_SRC{~blocked_s}};
    end
`endif

    assign elig_s     = bus.pend_i & ~isr_r[NUM_SRC-1:0] & allow_s;
    assign nmi_elig_s = bus.nmi_i & ~isr_r[NUM_SRC];

    intr_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_enc (
        .vec   (elig_s),
        .idx   (enc_idx_s),
        .found (enc_found_s)
    );

    assign win_valid_s = nmi_elig_s | enc_found_s;
    assign win_vec_s   = nmi_elig_s ? VEC_NMI : enc_idx_s;

    // Handshake sequencing; all outputs are computed here and registered below.
    always_comb begin
        state_nxt_s     = state_r;
        cand_nxt_s      = cand_r;
        irq_nxt_s       = 1'b0;
        nmi_nxt_s       = 1'b0;
        vec_valid_nxt_s = 1'b0;
        clr_nxt_s       = '0;
        nmi_clr_nxt_s   = 1'b0;
        isr_set_s       = '0;
        case (state_r)
            ST_IDLE: begin
                if (win_valid_s) begin
                    state_nxt_s = ST_REQ;
                    cand_nxt_s  = win_vec_s;
                    irq_nxt_s   = ~nmi_elig_s;
                    nmi_nxt_s   = nmi_elig_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.int_ack_i) begin
                    // Acked candidate goes in service; request drops at this edge.
                    state_nxt_s     = ST_ACK;
                    vec_valid_nxt_s = 1'b1;
                    if (cand_r == VEC_NMI) begin
                        nmi_clr_nxt_s    = 1'b1;
                        isr_set_s        = ISR_W'(1) << NUM_SRC;
                    end else begin
                        clr_nxt_s        = NUM_SRC'(1) << cand_r;
                        isr_set_s        = ISR_W'(1) << cand_r;
                    end
                end else if (win_valid_s) begin
                    // Re-evaluate every cycle so a better source preempts.
                    state_nxt_s = ST_REQ;
                    cand_nxt_s  = win_vec_s;
                    irq_nxt_s   = ~nmi_elig_s;
                    nmi_nxt_s   = nmi_elig_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACK: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // EOI retires one in-service bit; a same-cycle ack set takes precedence.
    always_comb begin
        if (bus.eoi_i && (bus.eoi_id_i <= ID_W'(NUM_SRC))) begin
            eoi_clr_s = ISR_W'(1) << bus.eoi_id_i;
        end else begin
            eoi_clr_s = '0;
        end
        isr_nxt_s = (isr_r & ~eoi_clr_s) | isr_set_s;
    end

    // State, candidate, in-service and output registers with synchronous reset.
    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            state_r     <= ST_IDLE;
            cand_r      <= '0;
            irq_r       <= 1'b0;
            nmi_r       <= 1'b0;
            vec_valid_r <= 1'b0;
            clr_r       <= '0;
            nmi_clr_r   <= 1'b0;
            isr_r       <= '0;
        end else begin
            state_r     <= state_nxt_s;
            cand_r      <= cand_nxt_s;
            irq_r       <= irq_nxt_s;
            nmi_r       <= nmi_nxt_s;
            vec_valid_r <= vec_valid_nxt_s;
            clr_r       <= clr_nxt_s;
            nmi_clr_r   <= nmi_clr_nxt_s;
            isr_r       <= isr_nxt_s;
        end
    end

    assign bus.irq_o       = irq_r;
    assign bus.nmi_o       = nmi_r;
    assign bus.vec_o       = cand_r;
    assign bus.vec_valid_o = vec_valid_r;
    assign bus.clr_o       = clr_r;
    assign bus.nmi_clr_o   = nmi_clr_r;
    assign bus.isr_o       = isr_r;

endmodule

// File: tb/tb_intr_prio_ctrl.sv
// Directed bench for intr_prio_ctrl. Expected values are hand-computed;
// the nesting-dependent expectations follow INTR_NEST_EN.
module tb_intr_prio_ctrl;

    logic pclk;
    logic preset_n;
    int   n_checks;
    int   n_fail;

    intr_prio_ctrl_if #(.NUM_SRC(16), .ID_W(5)) bus ();

    intr_prio_ctrl #(.NUM_SRC(16), .ID_W(5)) dut (
        .pclk     (pclk),
        .preset_n (preset_n),
        .bus      (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    initial begin
        n_checks          = 0;
        n_fail            = 0;
        preset_n          = 1'b0;
        bus.pend_i        = 16'h0000;
        bus.nmi_i         = 1'b0;
        bus.int_ack_i     = 1'b0;
        bus.eoi_i         = 1'b0;
        bus.eoi_id_i      = 5'd0;
        tick();
        tick();
        check_val("rst_irq", 32'(bus.irq_o), 32'd0);
        check_val("rst_nmi", 32'(bus.nmi_o), 32'd0);
        check_val("rst_isr", 32'(bus.isr_o), 32'd0);
        check_val("rst_vv",  32'(bus.vec_valid_o), 32'd0);
        check_val("rst_clr", 32'(bus.clr_o), 32'd0);
        preset_n = 1'b1;
        tick();

        // Basic request and ack of the lowest pending index.
        bus.pend_i = 16'h0030;
        tick();
        check_val("t1_irq", 32'(bus.irq_o), 32'd1);
        check_val("t1_nmi", 32'(bus.nmi_o), 32'd0);
        check_val("t1_vec", 32'(bus.vec_o), 32'd4);
        bus.int_ack_i = 1'b1;
        tick();
        bus.int_ack_i = 1'b0;
        check_val("t1_vv",     32'(bus.vec_valid_o), 32'd1);
        check_val("t1_vv_vec", 32'(bus.vec_o), 32'd4);
        check_val("t1_clr",    32'(bus.clr_o), 32'h0010);
        check_val("t1_irq_lo", 32'(bus.irq_o), 32'd0);
        check_val("t1_isr",    32'(bus.isr_o), 32'h00010);
        bus.pend_i = 16'h0020;
        tick();
        check_val("t1_vv_end",  32'(bus.vec_valid_o), 32'd0);
        check_val("t1_clr_end", 32'(bus.clr_o), 32'd0);
        tick();
        check_val("t1_blk_lo", 32'(bus.irq_o), 32'd0);

        // Higher-priority source while bit 4 is in service.
        bus.pend_i = 16'h0024;
        tick();
`ifdef INTR_NEST_EN
        check_val("nest_irq", 32'(bus.irq_o), 32'd1);
        check_val("nest_vec", 32'(bus.vec_o), 32'd2);
`else
        check_val("single_irq", 32'(bus.irq_o), 32'd0);
`endif
        bus.pend_i = 16'h0020;
        tick();
        check_val("nest_wd_irq", 32'(bus.irq_o), 32'd0);
        bus.eoi_i    = 1'b1;
        bus.eoi_id_i = 5'd4;
        tick();
        bus.eoi_i = 1'b0;
        check_val("eoi4_isr", 32'(bus.isr_o), 32'd0);
        tick();
        check_val("post_eoi_irq", 32'(bus.irq_o), 32'd1);
        check_val("post_eoi_vec", 32'(bus.vec_o), 32'd5);
        bus.pend_i = 16'h0000;
        tick();
        check_val("t3_drop", 32'(bus.irq_o), 32'd0);

        // Withdrawn pending bit.
        bus.pend_i = 16'h0080;
        tick();
        check_val("wd_irq", 32'(bus.irq_o), 32'd1);
        check_val("wd_vec", 32'(bus.vec_o), 32'd7);
        bus.pend_i = 16'h0000;
        tick();
        check_val("wd_irq_lo", 32'(bus.irq_o), 32'd0);
        tick();
        check_val("wd_clr", 32'(bus.clr_o), 32'd0);
        check_val("wd_vv",  32'(bus.vec_valid_o), 32'd0);
        check_val("wd_isr", 32'(bus.isr_o), 32'd0);

        // Preemption before ack: 8 then 0.
        bus.pend_i = 16'h0100;
        tick();
        check_val("pre_vec8", 32'(bus.vec_o), 32'd8);
        bus.pend_i = 16'h0101;
        tick();
        check_val("pre_vec0", 32'(bus.vec_o), 32'd0);
        check_val("pre_irq",  32'(bus.irq_o), 32'd1);
        bus.int_ack_i = 1'b1;
        tick();
        bus.int_ack_i = 1'b0;
        check_val("pre_vv",  32'(bus.vec_valid_o), 32'd1);
        check_val("pre_vvv", 32'(bus.vec_o), 32'd0);
        check_val("pre_clr", 32'(bus.clr_o), 32'h0001);
        check_val("pre_isr", 32'(bus.isr_o), 32'h00001);
        bus.pend_i = 16'h0100;
        tick();
        tick();
        check_val("pre_blk", 32'(bus.irq_o), 32'd0);
        bus.eoi_i    = 1'b1;
        bus.eoi_id_i = 5'd0;
        bus.pend_i   = 16'h0008;
        tick();
        bus.eoi_i = 1'b0;
        check_val("eoi0_isr", 32'(bus.isr_o), 32'd0);
        tick();
        check_val("v3_irq", 32'(bus.irq_o), 32'd1);
        check_val("v3_vec", 32'(bus.vec_o), 32'd3);

        // NMI preempts a maskable request.
        bus.nmi_i = 1'b1;
        tick();
        check_val("nmi_o",   32'(bus.nmi_o), 32'd1);
        check_val("nmi_irq", 32'(bus.irq_o), 32'd0);
        check_val("nmi_vec", 32'(bus.vec_o), 32'd16);
        bus.int_ack_i = 1'b1;
        tick();
        bus.int_ack_i = 1'b0;
        check_val("nmi_vv",    32'(bus.vec_valid_o), 32'd1);
        check_val("nmi_vvv",   32'(bus.vec_o), 32'd16);
        check_val("nmi_clr",   32'(bus.nmi_clr_o), 32'd1);
        check_val("nmi_clr_m", 32'(bus.clr_o), 32'd0);
        check_val("nmi_isr",   32'(bus.isr_o), 32'h10000);
        tick();
        check_val("nmi_clr_end", 32'(bus.nmi_clr_o), 32'd0);
        tick();
        check_val("nmi2_ign", 32'(bus.nmi_o), 32'd0);
        check_val("nmi2_irq", 32'(bus.irq_o), 32'd1);
        check_val("nmi2_vec", 32'(bus.vec_o), 32'd3);
        bus.eoi_i    = 1'b1;
        bus.eoi_id_i = 5'd16;
        tick();
        bus.eoi_i = 1'b0;
        check_val("eoi16_isr", 32'(bus.isr_o), 32'd0);
        check_val("eoi16_nmi", 32'(bus.nmi_o), 32'd0);
        tick();
        check_val("nmi3_o",   32'(bus.nmi_o), 32'd1);
        check_val("nmi3_vec", 32'(bus.vec_o), 32'd16);
        bus.nmi_i  = 1'b0;
        bus.pend_i = 16'h0000;
        tick();
        check_val("nmi3_drop", 32'(bus.nmi_o), 32'd0);

        // Same-cycle ack and EOI on one id; out-of-range EOI; stray acks.
        bus.pend_i = 16'h0002;
        tick();
        check_val("sc_vec", 32'(bus.vec_o), 32'd1);
        bus.int_ack_i = 1'b1;
        bus.eoi_i     = 1'b1;
        bus.eoi_id_i  = 5'd1;
        tick();
        check_val("sc_isr", 32'(bus.isr_o), 32'h00002);
        check_val("sc_clr", 32'(bus.clr_o), 32'h0002);
        bus.pend_i   = 16'h0000;
        bus.eoi_id_i = 5'd17;
        tick();
        bus.eoi_i = 1'b0;
        check_val("eoi17_isr", 32'(bus.isr_o), 32'h00002);
        check_val("ack_in_ack", 32'(bus.vec_valid_o), 32'd0);
        tick();
        bus.int_ack_i = 1'b0;
        check_val("ack_idle_vv",  32'(bus.vec_valid_o), 32'd0);
        check_val("ack_idle_isr", 32'(bus.isr_o), 32'h00002);
        bus.eoi_i    = 1'b1;
        bus.eoi_id_i = 5'd1;
        tick();
        bus.eoi_i = 1'b0;
        check_val("eoi1_isr", 32'(bus.isr_o), 32'd0);

        // Reset during REQ with a nonzero in-service set.
        bus.nmi_i = 1'b1;
        tick();
        bus.int_ack_i = 1'b1;
        tick();
        bus.int_ack_i = 1'b0;
        bus.nmi_i     = 1'b0;
        bus.pend_i    = 16'hFFFF;
        tick();
        tick();
        check_val("rq_irq", 32'(bus.irq_o), 32'd1);
        check_val("rq_vec", 32'(bus.vec_o), 32'd0);
        check_val("rq_isr", 32'(bus.isr_o), 32'h10000);
        preset_n      = 1'b0;
        bus.int_ack_i = 1'b1;
        tick();
        check_val("mrst_irq", 32'(bus.irq_o), 32'd0);
        check_val("mrst_isr", 32'(bus.isr_o), 32'd0);
        check_val("mrst_vv",  32'(bus.vec_valid_o), 32'd0);
        preset_n      = 1'b1;
        bus.int_ack_i = 1'b0;
        tick();
        check_val("rel_irq", 32'(bus.irq_o), 32'd1);
        check_val("rel_vec", 32'(bus.vec_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
